uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
- Client-side controller for the UART core; drives the core's transmit handshake and consumes its receive flag and clear handshake.
- Buffers outgoing bytes in a TX FIFO and feeds them to the transmitter, honouring its busy flag.
- Captures received bytes into an RX FIFO, drops parity-error bytes, and acknowledges each byte via the flag-clear line.
- Sits between the UART core and application logic (keyboard/display datapath).

Parameters:
- DEPTH_LOG2, 3, log2 of each FIFO depth (depth = 2**DEPTH_LOG2, 8 entries by default); must be at least 1.

Ports:
- iClk  in  1  system clock.
- iRst  in  1  synchronous reset, active-high.
- iRx_flag  in  1  UART core data-valid flag.
- iRx_data  in  8  UART core received byte; valid while iRx_flag=1.
- iPar_err  in  1  UART core parity error; qualifies iRx_data.
- oRx_flag_clr  out  1  flag-clear request to the UART core.
- iBusy  in  1  UART transmitter busy.
- oTx_send  out  1  transmit start request.
- oTx_data  out  8  byte to transmit.
- iWr_en  in  1  push iWr_data into the TX FIFO.
- iWr_data  in  8  byte to send.
- oTx_full  out  1  TX FIFO full.
- oTx_level  out  DEPTH_LOG2+1  TX FIFO occupancy.
- iRd_en  in  1  pop the RX FIFO head.
- oRd_data  out  8  RX FIFO head (first-word fall-through); valid when oRx_empty=0.
- oRx_empty  out  1  RX FIFO empty.
- oRx_level  out  DEPTH_LOG2+1  RX FIFO occupancy.
- oOverrun  out  1  sticky: a good byte was dropped because the RX FIFO was full.
- oPar_cnt  out  8  saturating count of bytes dropped for parity error.
- iClr_err  in  1  clears oOverrun and oPar_cnt.

Behaviour:
- Reset: both FIFOs empty, levels 0, oTx_full=0, oRx_empty=1, oTx_send=0, oTx_data=0, oRx_flag_clr=0, oOverrun=0, oPar_cnt=0, both FSMs idle.
- Reset mid-operation aborts any handshake immediately and discards all buffered bytes. The UART core's own frame is not affected.
- All outputs are registered; only the oRd_data and level/flag outputs are decoded from FIFO state.
- TX FIFO push:
  - iWr_en with oTx_full=0 stores the byte at the edge.
  - iWr_en while full is ignored; no overwrite, no flag.
  - Push and pop in the same cycle leave oTx_level unchanged.
- TX FSM, states T_IDLE, T_START, T_WAIT:
  - T_IDLE: when the FIFO is non-empty and iBusy=0, pop the head into oTx_data, set oTx_send=1, go to T_START. A byte written into an empty FIFO at edge k produces oTx_send=1 after edge k+1.
  - T_START: hold oTx_send=1 and oTx_data stable until iBusy=1 is sampled. Then clear oTx_send and go to T_WAIT.
  - T_WAIT: when iBusy=0, go to T_IDLE. Back-to-back bytes are spaced by at least one idle cycle.
- RX FSM, states R_IDLE, R_ACK:
  - R_IDLE: iRx_flag=1 is handled as follows:
    - iPar_err=1: the byte is dropped and oPar_cnt increments, saturating at 255.
    - RX FIFO not full, or full with iRd_en=1 in the same cycle: iRx_data is pushed.
    - Full with no concurrent pop: the byte is dropped and oOverrun is set.
    - In every case set oRx_flag_clr=1 and go to R_ACK.
  - R_ACK: hold oRx_flag_clr=1 until iRx_flag=0 is sampled, then clear it and go to R_IDLE. Each received byte is captured exactly once.
- RX pop: iRd_en with oRx_empty=0 advances the head. iRd_en while empty is ignored.
- iClr_err: clears oOverrun and oPar_cnt. If an error event occurs in the same cycle, the error event wins.
- Pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1). Full is when the MSBs differ and the remaining bits are equal.

Test Plan:
- Reset, then write 0x41 with iBusy=0 -> oTx_send=1 and oTx_data=0x41 two edges after the write. Raise iBusy -> oTx_send=0 next edge. Drop iBusy -> T_IDLE, oTx_level=0.
- Write 9 bytes 0x00..0x08 while iBusy=1 (DEPTH_LOG2=3) -> oTx_full=1 after 8 writes and 0x08 is discarded. Release iBusy and emulate the UART -> 0x00..0x07 are sent in order.
- Pulse iRx_flag with iRx_data=0x5A, iPar_err=0 -> oRx_flag_clr=1 next edge, held until the flag drops. oRd_data=0x5A, oRx_level=1. iRd_en -> oRx_empty=1.
- Send 0x33 with iPar_err=1 -> oRx_level unchanged, oPar_cnt=1, flag still acknowledged. Then iClr_err -> oPar_cnt=0.
- Fill the RX FIFO with 8 bytes, then deliver a 9th (0xEE) with no read -> oOverrun=1 and the FIFO contents are unchanged. Deliver another byte with iRd_en=1 in the capture cycle -> it is accepted, oRx_level stays 8.
- Assert iRst while in T_START and R_ACK -> next edge oTx_send=0, oRx_flag_clr=0, both levels 0.

Source files
------------

// File: rtl/uart_host_ctrl_if.sv
// Signal bundle between uart_host_ctrl, the UART core and the application side.
// The controller uses the slave modport; the driving environment uses master.
interface uart_host_ctrl_if #(
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  iRx_flag;
  logic [7:0]            iRx_data;
  logic                  iPar_err;
  logic                  oRx_flag_clr;
  logic                  iBusy;
  logic                  oTx_send;
  logic [7:0]            oTx_data;
  logic                  iWr_en;
  logic [7:0]            iWr_data;
  logic                  oTx_full;
  logic [DEPTH_LOG2:0]   oTx_level;
  logic                  iRd_en;
  logic [7:0]            oRd_data;
  logic                  oRx_empty;
  logic [DEPTH_LOG2:0]   oRx_level;
  logic                  oOverrun;
  logic [7:0]            oPar_cnt;
  logic                  iClr_err;

  modport slave (
    input  iRx_flag, iRx_data, iPar_err, iBusy, iWr_en, iWr_data, iRd_en, iClr_err,
    output oRx_flag_clr, oTx_send, oTx_data, oTx_full, oTx_level,
           oRd_data, oRx_empty, oRx_level, oOverrun, oPar_cnt
  );

  modport master (
    output iRx_flag, iRx_data, iPar_err, iBusy, iWr_en, iWr_data, iRd_en, iClr_err,
    input  oRx_flag_clr, oTx_send, oTx_data, oTx_full, oTx_level,
           oRd_data, oRx_empty, oRx_level, oOverrun, oPar_cnt
  );
endinterface

// File: rtl/uart_host_ctrl.sv
// Host-side UART controller: TX FIFO feeding the transmitter handshake and
// RX FIFO capturing flagged bytes with parity-drop and overrun tracking.
module uart_host_ctrl #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic            iClk,
  input  logic            iRst,
  uart_host_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT} tx_state_t;
  typedef enum logic       {R_IDLE, R_ACK}           rx_state_t;

  tx_state_t tx_state, tx_state_nxt;
  rx_state_t rx_state, rx_state_nxt;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic          tx_send_q, tx_send_nxt;
  logic [7:0]    tx_data_q;

  assign tx_full  = (tx_wr_ptr[PW-1] != tx_rd_ptr[PW-1]) &&
                    (tx_wr_ptr[PW-2:0] == tx_rd_ptr[PW-2:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign tx_push  = bus.iWr_en && !tx_full;
  assign tx_pop   = (tx_state == T_IDLE) && !tx_empty && !bus.iBusy;

  always_ff @(posedge iClk) begin
    if (tx_push) tx_mem[tx_wr_ptr[PW-2:0]] <= bus.iWr_data;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
    end
  end

  // ---------------- TX FSM ----------------
  always_ff @(posedge iClk) begin
    if (iRst) tx_state <= T_IDLE;
    else      tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      T_IDLE:  if (tx_pop)      tx_state_nxt = T_START;
      T_START: if (bus.iBusy)   tx_state_nxt = T_WAIT;
      T_WAIT:  if (!bus.iBusy)  tx_state_nxt = T_IDLE;
      default:                  tx_state_nxt = T_IDLE;
    endcase
  end

  // Next value of the registered send strobe; it follows the state it enters.
  always_comb begin
    tx_send_nxt = 1'b0;
    case (tx_state)
      T_IDLE:  tx_send_nxt = tx_pop;
      T_START: tx_send_nxt = !bus.iBusy;
      default: tx_send_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      tx_send_q <= tx_send_nxt;
      if (tx_pop) tx_data_q <= tx_mem[tx_rd_ptr[PW-2:0]];
    end
  end

  assign bus.oTx_send  = tx_send_q;
  assign bus.oTx_data  = tx_data_q;
  assign bus.oTx_full  = tx_full;
  assign bus.oTx_level = tx_wr_ptr - tx_rd_ptr;

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic          rx_capture, par_event, ovr_event;
  logic          flag_clr_q, flag_clr_nxt;
  logic          overrun_q;
  logic [7:0]    par_cnt_q;

  assign rx_full    = (rx_wr_ptr[PW-1] != rx_rd_ptr[PW-1]) &&
                      (rx_wr_ptr[PW-2:0] == rx_rd_ptr[PW-2:0]);
  assign rx_empty   = (rx_wr_ptr == rx_rd_ptr);
  assign rx_pop     = bus.iRd_en && !rx_empty;
  assign rx_capture = (rx_state == R_IDLE) && bus.iRx_flag;
  assign par_event  = rx_capture && bus.iPar_err;
  // When full, a same-cycle pop frees the slot the new byte lands in.
  assign rx_push    = rx_capture && !bus.iPar_err && (!rx_full || bus.iRd_en);
  assign ovr_event  = rx_capture && !bus.iPar_err && rx_full && !bus.iRd_en;

  always_ff @(posedge iClk) begin
    if (rx_push) rx_mem[rx_wr_ptr[PW-2:0]] <= bus.iRx_data;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
    end
  end

  // ---------------- RX FSM ----------------
  always_ff @(posedge iClk) begin
    if (iRst) rx_state <= R_IDLE;
    else      rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      R_IDLE:  if (bus.iRx_flag)  rx_state_nxt = R_ACK;
      R_ACK:   if (!bus.iRx_flag) rx_state_nxt = R_IDLE;
      default:                    rx_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    flag_clr_nxt = 1'b0;
    case (rx_state)
      R_IDLE:  flag_clr_nxt = bus.iRx_flag;
      R_ACK:   flag_clr_nxt = bus.iRx_flag;
      default: flag_clr_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      flag_clr_q <= 1'b0;
      overrun_q  <= 1'b0;
      par_cnt_q  <= '0;
    end else begin
      flag_clr_q <= flag_clr_nxt;
      if (ovr_event)         overrun_q <= 1'b1;
      else if (bus.iClr_err) overrun_q <= 1'b0;
      if (par_event) begin
        if (par_cnt_q != 8'hFF) par_cnt_q <= par_cnt_q + 8'd1;
      end else if (bus.iClr_err) begin
        par_cnt_q <= '0;
      end
    end
  end

  assign bus.oRx_flag_clr = flag_clr_q;
  assign bus.oRd_data     = rx_mem[rx_rd_ptr[PW-2:0]];
  assign bus.oRx_empty    = rx_empty;
  assign bus.oRx_level    = rx_wr_ptr - rx_rd_ptr;
  assign bus.oOverrun     = overrun_q;
  assign bus.oPar_cnt     = par_cnt_q;
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Scoreboard bench for uart_host_ctrl: stimulus queues expected TX/RX bytes,
// a UART emulator and an RX reader monitor pop and compare them.
module tb_uart_host_ctrl;
  localparam int unsigned DL2 = 3;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  logic busy_force = 1'b0;
  logic emu_busy   = 1'b0;
  logic emu_en     = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  uart_host_ctrl_if #(.DEPTH_LOG2(DL2)) bus ();

  uart_host_ctrl #(.DEPTH_LOG2(DL2)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  always #5 iClk = ~iClk;

  assign bus.iBusy = busy_force | emu_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART transmitter emulator: accepts a byte on oTx_send, stays busy a few cycles.
  initial begin
    forever begin
      @(negedge iClk);
      if (!iRst && emu_en && !emu_busy && bus.oTx_send) begin
        checks++;
        if (exp_tx.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got 0x%0h expected no transmission", bus.oTx_data);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (bus.oTx_data !== e) begin
            errors++;
            $display("FAIL tx_data: got 0x%0h expected 0x%0h", bus.oTx_data, e);
          end
        end
        emu_busy = 1'b1;
        repeat (3) @(negedge iClk);
        emu_busy = 1'b0;
      end
    end
  end

  // RX reader monitor: every accepted pop is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge iClk);
      if (!iRst && bus.iRd_en && !bus.oRx_empty) begin
        checks++;
        if (exp_rx.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got 0x%0h expected no data", bus.oRd_data);
        end else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          if (bus.oRd_data !== e) begin
            errors++;
            $display("FAIL rx_data: got 0x%0h expected 0x%0h", bus.oRd_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr_byte(input logic [7:0] d);
    bus.iWr_en = 1'b1;
    bus.iWr_data = d;
    @(posedge iClk); #1;
    bus.iWr_en = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic par, input logic rd, input int hold);
    bus.iRx_flag = 1'b1;
    bus.iRx_data = d;
    bus.iPar_err = par;
    bus.iRd_en   = rd;
    if (!par && (exp_rx.size() < 8 || rd)) exp_rx.push_back(d);
    @(posedge iClk); #1;
    bus.iRd_en = 1'b0;
    chk("rx_flag_clr_set", 32'(bus.oRx_flag_clr), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge iClk); #1;
      chk("rx_flag_clr_held", 32'(bus.oRx_flag_clr), 32'd1);
    end
    bus.iRx_flag = 1'b0;
    bus.iPar_err = 1'b0;
    @(posedge iClk); #1;
    chk("rx_flag_clr_drop", 32'(bus.oRx_flag_clr), 32'd0);
  endtask

  task automatic rd_n(input int n);
    bus.iRd_en = 1'b1;
    repeat (n) @(posedge iClk);
    #1;
    bus.iRd_en = 1'b0;
  endtask

  initial begin
    bus.iRx_flag = 1'b0; bus.iRx_data = '0; bus.iPar_err = 1'b0;
    bus.iWr_en = 1'b0;   bus.iWr_data = '0; bus.iRd_en = 1'b0;
    bus.iClr_err = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;

    // Reset state
    chk("rst_tx_send",  32'(bus.oTx_send),     32'd0);
    chk("rst_tx_data",  32'(bus.oTx_data),     32'd0);
    chk("rst_flag_clr", 32'(bus.oRx_flag_clr), 32'd0);
    chk("rst_tx_full",  32'(bus.oTx_full),     32'd0);
    chk("rst_tx_level", 32'(bus.oTx_level),    32'd0);
    chk("rst_rx_empty", 32'(bus.oRx_empty),    32'd1);
    chk("rst_rx_level", 32'(bus.oRx_level),    32'd0);
    chk("rst_overrun",  32'(bus.oOverrun),     32'd0);
    chk("rst_par_cnt",  32'(bus.oPar_cnt),     32'd0);

    // Single byte TX handshake timing
    wr_byte(8'h41);
    chk("t1_send_after_k",  32'(bus.oTx_send),  32'd0);
    chk("t1_level_after_k", 32'(bus.oTx_level), 32'd1);
    @(posedge iClk); #1;
    chk("t1_send_k1",  32'(bus.oTx_send),  32'd1);
    chk("t1_data_k1",  32'(bus.oTx_data),  32'h41);
    chk("t1_level_k1", 32'(bus.oTx_level), 32'd0);
    @(posedge iClk); #1;
    chk("t1_send_hold", 32'(bus.oTx_send), 32'd1);
    chk("t1_data_hold", 32'(bus.oTx_data), 32'h41);
    busy_force = 1'b1;
    @(posedge iClk); #1;
    chk("t1_send_clear", 32'(bus.oTx_send), 32'd0);
    busy_force = 1'b0;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    chk("t1_idle_send",  32'(bus.oTx_send),  32'd0);
    chk("t1_idle_level", 32'(bus.oTx_level), 32'd0);

    // TX FIFO fill while busy, overflow discarded, then drained in order
    busy_force = 1'b1;
    for (int i = 0; i < 8; i++) wr_byte(8'(i));
    chk("t2_full",     32'(bus.oTx_full),  32'd1);
    chk("t2_level8",   32'(bus.oTx_level), 32'd8);
    wr_byte(8'h08);
    chk("t2_full_keep",  32'(bus.oTx_full),  32'd1);
    chk("t2_level_keep", 32'(bus.oTx_level), 32'd8);
    chk("t2_no_send",    32'(bus.oTx_send),  32'd0);
    for (int i = 0; i < 8; i++) exp_tx.push_back(8'(i));
    emu_en = 1'b1;
    busy_force = 1'b0;
    for (int i = 0; i < 300 && exp_tx.size() != 0; i++) @(posedge iClk);
    #1;
    chk("t2_drained", 32'(exp_tx.size()), 32'd0);
    repeat (8) @(posedge iClk);
    #1;
    emu_en = 1'b0;
    chk("t2_level_end", 32'(bus.oTx_level), 32'd0);
    chk("t2_send_end",  32'(bus.oTx_send),  32'd0);
    chk("t2_full_end",  32'(bus.oTx_full),  32'd0);

    // RX good byte with flag held
    rx_byte(8'h5A, 1'b0, 1'b0, 2);
    chk("t3_rd_data",  32'(bus.oRd_data),  32'h5A);
    chk("t3_rx_level", 32'(bus.oRx_level), 32'd1);
    chk("t3_rx_empty", 32'(bus.oRx_empty), 32'd0);
    rd_n(1);
    chk("t3_empty_after_rd", 32'(bus.oRx_empty), 32'd1);
    rd_n(1);
    chk("t3_rd_empty_ignored", 32'(bus.oRx_level), 32'd0);

    // Parity error drop and clear
    rx_byte(8'h33, 1'b1, 1'b0, 0);
    chk("t4_level",   32'(bus.oRx_level), 32'd0);
    chk("t4_par_cnt", 32'(bus.oPar_cnt),  32'd1);
    chk("t4_overrun", 32'(bus.oOverrun),  32'd0);
    bus.iClr_err = 1'b1;
    @(posedge iClk); #1;
    bus.iClr_err = 1'b0;
    chk("t4_par_clr", 32'(bus.oPar_cnt), 32'd0);

    // RX overrun and full-with-pop acceptance
    for (int i = 0; i < 8; i++) rx_byte(8'(8'h10 + i), 1'b0, 1'b0, 0);
    chk("t5_level8", 32'(bus.oRx_level), 32'd8);
    rx_byte(8'hEE, 1'b0, 1'b0, 0);
    chk("t5_overrun",    32'(bus.oOverrun),  32'd1);
    chk("t5_level_keep", 32'(bus.oRx_level), 32'd8);
    chk("t5_head_keep",  32'(bus.oRd_data),  32'h10);
    rx_byte(8'h77, 1'b0, 1'b1, 0);
    chk("t5_level_pop_push", 32'(bus.oRx_level), 32'd8);
    chk("t5_head_next",      32'(bus.oRd_data),  32'h11);
    rd_n(8);
    chk("t5_empty",     32'(bus.oRx_empty), 32'd1);
    chk("t5_sb_empty",  32'(exp_rx.size()), 32'd0);
    bus.iClr_err = 1'b1;
    @(posedge iClk); #1;
    bus.iClr_err = 1'b0;
    chk("t5_ovr_clr", 32'(bus.oOverrun), 32'd0);

    // Reset while in T_START and R_ACK
    wr_byte(8'h99);
    bus.iWr_en = 1'b1; bus.iWr_data = 8'hAA;
    bus.iRx_flag = 1'b1; bus.iRx_data = 8'h42;
    @(posedge iClk); #1;
    bus.iWr_en = 1'b0;
    chk("t6_send_pre",     32'(bus.oTx_send),     32'd1);
    chk("t6_data_pre",     32'(bus.oTx_data),     32'h99);
    chk("t6_flagclr_pre",  32'(bus.oRx_flag_clr), 32'd1);
    chk("t6_txlevel_pre",  32'(bus.oTx_level),    32'd1);
    chk("t6_rxlevel_pre",  32'(bus.oRx_level),    32'd1);
    iRst = 1'b1;
    bus.iRx_flag = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b0;
    chk("t6_send_rst",    32'(bus.oTx_send),     32'd0);
    chk("t6_flagclr_rst", 32'(bus.oRx_flag_clr), 32'd0);
    chk("t6_txlevel_rst", 32'(bus.oTx_level),    32'd0);
    chk("t6_rxlevel_rst", 32'(bus.oRx_level),    32'd0);
    chk("t6_rxempty_rst", 32'(bus.oRx_empty),    32'd1);
    repeat (3) @(posedge iClk);
    #1;
    chk("t6_no_resend", 32'(bus.oTx_send), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
